// File: rtl/ahb3lite_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// Bus bundles for the AHB3-Lite to APB bridge.
//
// ahb3lite_if : AHB3-Lite slave-port bundle.
//   master modport drives HSEL/HADDR/HWRITE/HSIZE/HTRANS/HPROT/HREADY/HWDATA
//   and receives HRDATA/HREADYOUT/HRESP.
//   slave modport is the mirror image and is used by the bridge.
// apb_if      : APB bundle.
//   master modport (used by the bridge) drives PSEL/PENABLE/PADDR/PWRITE/
//   PPROT/PSTRB/PWDATA and receives PRDATA/PREADY/PSLVERR.
//   slave modport is the mirror image for the downstream APB mux.
// ---------------------------------------------------------------------------
interface ahb3lite_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic [3:0]            HPROT;
  logic                  HREADY;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HPROT, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HPROT, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

interface apb_if #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic                    PWRITE;
  logic [2:0]              PPROT;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PPROT, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PPROT, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb3lite_apb_bridge.sv
// ---------------------------------------------------------------------------
// AHB3-Lite slave to APB master bridge, single clock domain.
//
// Ports:
//   PRESETn : asynchronous active-low reset
//   PCLK    : clock shared by the AHB and APB sides
//   ahb     : ahb3lite_if.slave  (HSEL..HWDATA in, HRDATA/HREADYOUT/HRESP out)
//   apb     : apb_if.master      (PSEL..PWDATA out, PRDATA/PREADY/PSLVERR in)
//
// An accepted AHB address phase is captured into the APB address/control
// registers, then the bridge walks SETUP -> ACCESS (-> ERROR on PSLVERR).
// The AHB data phase is stretched with HREADYOUT=0 until PREADY returns.
// ---------------------------------------------------------------------------
module ahb3lite_apb_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 32
) (
  input logic       PRESETn,
  input logic       PCLK,
  ahb3lite_if.slave ahb,
  apb_if.master     apb
);

  localparam int BYTES     = HDATA_SIZE / 8;
  localparam int LANE_BITS = $clog2(BYTES);

  if (PDATA_SIZE != HDATA_SIZE) begin : g_data_width_check
    $error("ahb3lite_apb_bridge: PDATA_SIZE must equal HDATA_SIZE");
  end

  if (PADDR_SIZE > HADDR_SIZE) begin : g_addr_width_check
    $error("ahb3lite_apb_bridge: PADDR_SIZE must not exceed HADDR_SIZE");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;

  state_t                state, next_state;
  logic                  request, accept;
  logic                  hreadyout, hresp;
  logic                  psel, penable, pwrite;
  logic [PADDR_SIZE-1:0] paddr;
  logic [BYTES-1:0]      pstrb, strb_next;
  logic [2:0]            pprot;
  int                    lane;
  logic                  unused_inputs;

  // A NONSEQ/SEQ transfer aimed at this slave; it is only taken on a cycle
  // where the bridge itself is ready, which the FSM knows per state.
  assign request = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign accept  = request & hreadyout;

  // Address bits above the APB window, HTRANS[0] and HPROT[3:2] have no
  // APB counterpart.
  assign unused_inputs = ^{ahb.HADDR, ahb.HTRANS, ahb.HPROT};

  // Byte-lane strobes for a write: the lanes covered by an HSIZE-aligned
  // beat containing the addressed byte, or every lane when the beat is at
  // least as wide as the bus.
  always_comb begin
    lane = 0;
    for (int b = 0; b < LANE_BITS; b++) begin
      if (ahb.HADDR[b]) lane = lane | (1 << b);
    end
    strb_next = '0;
    if (ahb.HWRITE) begin
      if (int'(ahb.HSIZE) >= LANE_BITS) begin
        strb_next = '1;
      end else begin
        for (int i = 0; i < BYTES; i++) begin
          strb_next[i] = ((i >> ahb.HSIZE) == (lane >> ahb.HSIZE));
        end
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= next_state;
  end

  // Next state plus the AHB response. Only ACCESS looks at PREADY/PSLVERR,
  // so that is the one place the response is combinational on the APB side.
  always_comb begin
    next_state = state;
    hreadyout  = 1'b1;
    hresp      = 1'b0;
    unique case (state)
      IDLE: begin
        if (request) next_state = SETUP;
      end
      SETUP: begin
        hreadyout  = 1'b0;
        next_state = ACCESS;
      end
      ACCESS: begin
        hreadyout = 1'b0;
        if (apb.PREADY) begin
          if (apb.PSLVERR) begin
            hresp      = 1'b1;
            next_state = ERROR;
          end else begin
            hreadyout  = 1'b1;
            next_state = request ? SETUP : IDLE;
          end
        end
      end
      ERROR: begin
        hresp      = 1'b1;
        next_state = request ? SETUP : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // PSEL/PENABLE come straight from flops, decoded from the state being
  // entered, so they never glitch.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      psel    <= (next_state == SETUP) || (next_state == ACCESS);
      penable <= (next_state == ACCESS);
    end
  end

  // Address/control are only loaded on an accepted address phase, which
  // cannot happen while HREADYOUT is low, so they hold through ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pstrb  <= '0;
      pprot  <= '0;
    end else if (accept) begin
      paddr  <= ahb.HADDR[PADDR_SIZE-1:0];
      pwrite <= ahb.HWRITE;
      pstrb  <= strb_next;
      pprot  <= {~ahb.HPROT[0], 1'b1, ahb.HPROT[1]};
    end
  end

  assign ahb.HREADYOUT = hreadyout;
  assign ahb.HRESP     = hresp;
  assign ahb.HRDATA    = apb.PRDATA;

  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  assign apb.PADDR   = paddr;
  assign apb.PWRITE  = pwrite;
  assign apb.PSTRB   = pstrb;
  assign apb.PPROT   = pprot;
  // The AHB master holds HWDATA for the whole stretched data phase.
  assign apb.PWDATA  = ahb.HWDATA;

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ahb3lite_apb_bridge.
// Drives a list of directed and random AHB transfers against a randomly
// behaving APB slave and compares the bridge against a transfer-level
// timeline model: each transfer spends one SETUP cycle, waits+1 ACCESS
// cycles, and one extra ERROR-response cycle when the slave flags an error.
// ---------------------------------------------------------------------------
module tb_ahb3lite_apb_bridge;

  localparam int HADDR_SIZE = 32;
  localparam int HDATA_SIZE = 32;
  localparam int PADDR_SIZE = 10;
  localparam int PDATA_SIZE = 32;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;

  always #5 PCLK = ~PCLK;

  ahb3lite_if #(.HADDR_SIZE(HADDR_SIZE), .HDATA_SIZE(HDATA_SIZE)) ahb ();
  apb_if      #(.PADDR_SIZE(PADDR_SIZE), .PDATA_SIZE(PDATA_SIZE)) apb ();

  // Single slave on the bus, so the bus-wide HREADY is this slave's own.
  assign ahb.HREADY = ahb.HREADYOUT;

  ahb3lite_apb_bridge #(
    .HADDR_SIZE(HADDR_SIZE),
    .HDATA_SIZE(HDATA_SIZE),
    .PADDR_SIZE(PADDR_SIZE),
    .PDATA_SIZE(PDATA_SIZE)
  ) dut (
    .PRESETn(PRESETn),
    .PCLK   (PCLK),
    .ahb    (ahb),
    .apb    (apb)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [1:0]  trans;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          err;
    int          gap;
  } xfer_t;

  xfer_t txq[$];
  int    checks = 0;
  int    errors = 0;

  // Every comparison of the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Strobes from plain byte arithmetic: a beat of 2^size bytes, placed at
  // the address offset rounded down to the beat size.
  function automatic logic [3:0] refStrb(input xfer_t t);
    int beatBytes;
    int offset;
    if (!t.write) return 4'h0;
    beatBytes = 1 << t.size;
    if (beatBytes >= 4) return 4'hF;
    offset = int'(t.addr[1:0]);
    offset = (offset / beatBytes) * beatBytes;
    return 4'(((1 << beatBytes) - 1) << offset);
  endfunction

  function automatic logic [2:0] refProt(input logic [3:0] p);
    return {~p[0], 1'b1, p[1]};
  endfunction

  function automatic xfer_t makeXfer(input bit write, input logic [31:0] addr,
                                     input logic [2:0] size, input logic [31:0] wdata,
                                     input logic [31:0] rdata, input int waits,
                                     input bit err, input int gap);
    xfer_t t;
    t.write = write;
    t.addr  = addr;
    t.size  = size;
    t.prot  = 4'($urandom);
    t.trans = 2'b10;
    t.wdata = wdata;
    t.rdata = rdata;
    t.waits = waits;
    t.err   = err;
    t.gap   = gap;
    return t;
  endfunction

  // Presents a transfer's address phase, or one of the non-transfer patterns
  // (deselected, IDLE, BUSY) with random address-phase fields.
  task automatic applyStimulus(input bit present, input xfer_t t);
    if (present) begin
      ahb.HSEL   = 1'b1;
      ahb.HTRANS = t.trans;
      ahb.HADDR  = t.addr;
      ahb.HWRITE = t.write;
      ahb.HSIZE  = t.size;
      ahb.HPROT  = t.prot;
    end else begin
      ahb.HADDR  = $urandom;
      ahb.HWRITE = 1'($urandom);
      ahb.HSIZE  = 3'($urandom);
      ahb.HPROT  = 4'($urandom);
      case ($urandom_range(0, 2))
        0:       begin ahb.HSEL = 1'b0; ahb.HTRANS = 2'b10; end
        1:       begin ahb.HSEL = 1'b1; ahb.HTRANS = 2'b00; end
        default: begin ahb.HSEL = 1'b1; ahb.HTRANS = 2'b01; end
      endcase
    end
  endtask

  task automatic runTransfers();
    int    n;
    int    aidx;
    int    didx;
    int    dcyc;
    int    gapLeft;
    int    finalAcc;
    int    cyc;
    bit    dactive;
    bit    present;
    bit    lastAcc;
    bit    expPsel, expPen, expRdy, expResp;
    xfer_t t;
    n        = txq.size();
    aidx     = 0;
    didx     = 0;
    dcyc     = 0;
    finalAcc = 0;
    cyc      = 0;
    dactive  = 1'b0;
    gapLeft  = txq[0].gap;
    t        = txq[0];
    while ((aidx < n || dactive) && cyc < 3000) begin
      @(negedge PCLK);
      cyc++;
      present = (aidx < n) && (gapLeft == 0);
      if (dactive) begin
        t        = txq[didx];
        finalAcc = t.waits + 1;
      end
      if (!dactive) begin
        expPsel = 0; expPen = 0; expRdy = 1; expResp = 0;
      end else if (dcyc == 0) begin
        expPsel = 1; expPen = 0; expRdy = 0; expResp = 0;
      end else if (dcyc < finalAcc) begin
        expPsel = 1; expPen = 1; expRdy = 0; expResp = 0;
      end else if (dcyc == finalAcc) begin
        expPsel = 1; expPen = 1; expRdy = !t.err; expResp = t.err;
      end else begin
        expPsel = 0; expPen = 0; expRdy = 1; expResp = 1;
      end
      applyStimulus(present, (aidx < n) ? txq[aidx] : txq[n-1]);
      lastAcc      = dactive && (dcyc == finalAcc);
      ahb.HWDATA   = (dactive && t.write) ? t.wdata : $urandom;
      apb.PREADY   = (dactive && dcyc >= 1 && dcyc <= finalAcc) ? (dcyc == finalAcc)
                                                                : 1'($urandom);
      apb.PSLVERR  = lastAcc ? t.err : 1'($urandom);
      apb.PRDATA   = lastAcc ? t.rdata : $urandom;
      #1;
      checkOutput("psel",      64'(apb.PSEL),      64'(expPsel));
      checkOutput("penable",   64'(apb.PENABLE),   64'(expPen));
      checkOutput("hreadyout", 64'(ahb.HREADYOUT), 64'(expRdy));
      checkOutput("hresp",     64'(ahb.HRESP),     64'(expResp));
      if (dactive && expPsel) begin
        checkOutput("paddr",  64'(apb.PADDR),  64'(t.addr[PADDR_SIZE-1:0]));
        checkOutput("pwrite", 64'(apb.PWRITE), 64'(t.write));
        checkOutput("pstrb",  64'(apb.PSTRB),  64'(refStrb(t)));
        checkOutput("pprot",  64'(apb.PPROT),  64'(refProt(t.prot)));
        if (t.write) checkOutput("pwdata", 64'(apb.PWDATA), 64'(t.wdata));
      end
      if (lastAcc && !t.err && !t.write) begin
        checkOutput("hrdata", 64'(ahb.HRDATA), 64'(t.rdata));
      end
      if (dactive) begin
        if ((dcyc == finalAcc && !t.err) || dcyc > finalAcc) dactive = 1'b0;
        else dcyc++;
      end
      if (present && expRdy) begin
        dactive = 1'b1;
        didx    = aidx;
        dcyc    = 0;
        aidx++;
        if (aidx < n) gapLeft = txq[aidx].gap;
      end else if (!present && expRdy && aidx < n) begin
        gapLeft--;
      end
    end
    checkOutput("transfers_finished", 64'(aidx < n || dactive), 64'(0));
  endtask

  // Reset pulsed while the APB slave stalls in ACCESS, then a fresh write
  // straight after release to show the bridge starts from IDLE.
  task automatic resetDuringAccess();
    xfer_t t;
    xfer_t w;
    int    k;
    t = makeXfer(1'b0, 32'h0000_0230, 3'd2, 32'h0, 32'h5555_AAAA, 0, 1'b0, 0);
    w = makeXfer(1'b1, 32'h0000_03FE, 3'd1, 32'hBEEF_0000, 32'h0, 0, 1'b0, 0);
    @(negedge PCLK);
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    applyStimulus(1'b1, t);
    @(negedge PCLK);
    applyStimulus(1'b0, t);
    k = 0;
    while (!(apb.PSEL && apb.PENABLE) && k < 8) begin
      @(negedge PCLK);
      k++;
    end
    checkOutput("stall_in_access", 64'({apb.PSEL, apb.PENABLE}), 64'(2'b11));
    #2 PRESETn = 1'b0;
    #1;
    checkOutput("midrst_psel",      64'(apb.PSEL),      64'(0));
    checkOutput("midrst_penable",   64'(apb.PENABLE),   64'(0));
    checkOutput("midrst_hreadyout", 64'(ahb.HREADYOUT), 64'(1));
    checkOutput("midrst_hresp",     64'(ahb.HRESP),     64'(0));
    checkOutput("midrst_paddr",     64'(apb.PADDR),     64'(0));
    @(negedge PCLK);
    PRESETn     = 1'b1;
    apb.PREADY  = 1'b1;
    applyStimulus(1'b1, w);
    #1;
    checkOutput("postrst_hreadyout", 64'(ahb.HREADYOUT), 64'(1));
    @(negedge PCLK);
    applyStimulus(1'b0, w);
    ahb.HWDATA = w.wdata;
    #1;
    checkOutput("postrst_setup_psel",    64'(apb.PSEL),    64'(1));
    checkOutput("postrst_setup_penable", 64'(apb.PENABLE), 64'(0));
    checkOutput("postrst_paddr",         64'(apb.PADDR),   64'(10'h3FE));
    checkOutput("postrst_pstrb",         64'(apb.PSTRB),   64'(4'b1100));
    @(negedge PCLK);
    #1;
    checkOutput("postrst_access_penable",   64'(apb.PENABLE),   64'(1));
    checkOutput("postrst_access_hreadyout", 64'(ahb.HREADYOUT), 64'(1));
    checkOutput("postrst_pwdata",           64'(apb.PWDATA),    64'(32'hBEEF_0000));
    @(negedge PCLK);
    apb.PREADY = 1'b0;
  endtask

  initial begin
    xfer_t r;
    ahb.HWDATA  = '0;
    apb.PREADY  = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA  = '0;
    r = makeXfer(1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 0, 1'b0, 0);
    applyStimulus(1'b0, r);
    #1 PRESETn = 1'b0;
    #2;
    checkOutput("rst_psel",      64'(apb.PSEL),      64'(0));
    checkOutput("rst_penable",   64'(apb.PENABLE),   64'(0));
    checkOutput("rst_hreadyout", 64'(ahb.HREADYOUT), 64'(1));
    checkOutput("rst_hresp",     64'(ahb.HRESP),     64'(0));
    checkOutput("rst_paddr",     64'(apb.PADDR),     64'(0));
    checkOutput("rst_pwrite",    64'(apb.PWRITE),    64'(0));
    checkOutput("rst_pstrb",     64'(apb.PSTRB),     64'(0));
    checkOutput("rst_pprot",     64'(apb.PPROT),     64'(0));
    #4 PRESETn = 1'b1;

    // Directed: word read, byte and halfword writes back to back, a read
    // stalled five cycles, an error, then a write immediately followed by a read.
    txq.push_back(makeXfer(1'b0, 32'h0000_0104, 3'd2, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 0));
    txq.push_back(makeXfer(1'b1, 32'h0000_0003, 3'd0, 32'hAB00_0000, 32'h0,         0, 1'b0, 1));
    txq.push_back(makeXfer(1'b1, 32'h0000_0002, 3'd1, 32'h1234_0000, 32'h0,         1, 1'b0, 0));
    txq.push_back(makeXfer(1'b0, 32'h0000_0388, 3'd2, 32'h0,         32'h1357_9BDF, 5, 1'b0, 1));
    txq.push_back(makeXfer(1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 32'h0,         0, 1'b1, 1));
    txq.push_back(makeXfer(1'b1, 32'h0000_0020, 3'd2, 32'h0BAD_F00D, 32'h0,         0, 1'b0, 2));
    txq.push_back(makeXfer(1'b0, 32'h0000_0024, 3'd2, 32'h0,         32'h2468_ACE0, 0, 1'b0, 0));
    for (int i = 0; i < 60; i++) begin
      r = makeXfer(1'($urandom), $urandom, 3'($urandom_range(0, 3)), $urandom, $urandom,
                   int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                   int'($urandom_range(0, 2)));
      r.trans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      txq.push_back(r);
    end

    runTransfers();
    resetDuringAccess();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb3lite_apb_bridge.md
AHB3LITE_APB_BRIDGE -- requirements
Module: ahb3lite_apb_bridge

Interface
REQ-001 SHALL have parameter HADDR_SIZE, default 32, AHB address width.
REQ-002 SHALL have parameter HDATA_SIZE, default 32, AHB data width (8/16/32/64).
REQ-003 SHALL have parameter PADDR_SIZE, default 10, APB address width; PADDR_SIZE <= HADDR_SIZE.
REQ-004 SHALL have parameter PDATA_SIZE, default 32, APB data width; elaboration SHALL fail unless PDATA_SIZE == HDATA_SIZE.
REQ-005 SHALL use one clock; reset is asynchronous and active-low; ports named PCLK and PRESETn.
REQ-006 Port list: PRESETn in 1 async active-low reset; PCLK in 1 clock (shared by AHB and APB sides).
REQ-007 HSEL in 1 slave select; HADDR in HADDR_SIZE; HWRITE in 1; HSIZE in 3; HTRANS in 2; HPROT in 4; HREADY in 1 bus ready.
REQ-008 HWDATA in HDATA_SIZE; HRDATA out HDATA_SIZE; HREADYOUT out 1; HRESP out 1 (0=OKAY, 1=ERROR).
REQ-009 PSEL out 1; PENABLE out 1; PADDR out PADDR_SIZE; PWRITE out 1; PPROT out 3; PSTRB out PDATA_SIZE/8; PWDATA out PDATA_SIZE.
REQ-010 PRDATA in PDATA_SIZE; PREADY in 1; PSLVERR in 1 (driven by the downstream APB mux).

Function
REQ-011 FSM states SHALL be IDLE, SETUP, ACCESS, ERROR.
REQ-012 Transfer accepted when HSEL & HREADY & HTRANS in {NONSEQ, SEQ} in a cycle where HREADYOUT=1.
REQ-013 On accept, SHALL register PADDR=HADDR[PADDR_SIZE-1:0], PWRITE=HWRITE, PSTRB, PPROT; next state SETUP.
REQ-014 HTRANS IDLE/BUSY or HSEL=0 SHALL cause no APB access and no state change; OKAY, zero wait.
REQ-015 SETUP: PSEL=1, PENABLE=0, HREADYOUT=0, HRESP=0; next state ACCESS unconditionally.
REQ-016 ACCESS: PSEL=1, PENABLE=1; remain while PREADY=0 (no timeout), HREADYOUT=0.
REQ-017 ACCESS & PREADY & !PSLVERR: HREADYOUT=1, HRESP=0, HRDATA=PRDATA same cycle; next IDLE, or SETUP if a new transfer is accepted this cycle.
REQ-018 ACCESS & PREADY & PSLVERR: HREADYOUT=0, HRESP=1; next ERROR.
REQ-019 ERROR: PSEL=0, HREADYOUT=1, HRESP=1; next IDLE, or SETUP if a transfer is accepted this cycle.
REQ-020 PSEL and PENABLE SHALL be registered (glitch-free); HREADYOUT/HRESP may depend combinationally on PREADY/PSLVERR in ACCESS only.
REQ-021 PWDATA SHALL equal HWDATA during SETUP and ACCESS (master holds HWDATA stable while HREADYOUT=0).
REQ-022 PSTRB on write = ((2^(2^HSIZE))-1) << (HADDR mod (HDATA_SIZE/8)) aligned to HSIZE; HSIZE above bus width SHALL produce all-ones; PSTRB=0 on read.
REQ-023 PPROT[0]=HPROT[1]; PPROT[1]=1 (non-secure); PPROT[2]=~HPROT[0].
REQ-024 PADDR/PWRITE/PSTRB/PPROT SHALL hold stable from SETUP through the final ACCESS cycle.
REQ-025 Minimum latency: address phase + 2 wait-free cycles (SETUP, ACCESS); back-to-back transfers SHALL incur no extra IDLE cycle.
REQ-026 HRDATA outside a completing read is don't-care; writes SHALL never update HRDATA-dependent state.

Reset
REQ-027 PRESETn low SHALL force asynchronously: state IDLE, PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0, PADDR=0, PWRITE=0, PSTRB=0, PPROT=0.
REQ-028 Reset asserted mid-transfer SHALL abort it with no completion response; first cycle after release behaves as IDLE.

Verification
REQ-029 Word read HADDR=0x0000_0104, PREADY=1 in first ACCESS, PRDATA=0xCAFE_F00D -> PADDR=0x104, PSTRB=0, HRDATA=0xCAFE_F00D with HREADYOUT=1 two cycles after address phase.
REQ-030 Byte write HADDR=0x...03, HSIZE=0, HWDATA=0xAB00_0000 -> PSTRB=4'b1000, PWRITE=1, PWDATA=0xAB00_0000; halfword at 0x...02 -> PSTRB=4'b1100.
REQ-031 PREADY held low 5 cycles in ACCESS -> PSEL/PENABLE/PADDR stable, HREADYOUT=0 for 6 cycles, completes on 6th ACCESS cycle.
REQ-032 PSLVERR=1 with PREADY=1 -> HRESP=1/HREADYOUT=0 one cycle, then HRESP=1/HREADYOUT=1 one cycle, then IDLE.
REQ-033 Back-to-back NONSEQ write then read -> second SETUP immediately follows first completing ACCESS; PSEL stays 1, PENABLE drops to 0 for one cycle.
REQ-034 PRESETn pulsed low during ACCESS -> PSEL=0, PENABLE=0, HREADYOUT=1 immediately, no clock edge required.
